// File: rtl/yarvi_mem_arb_if.sv
// Bus bundle between the core/DMA requesters, the memory arbiter and the memory.
// slave: arbiter view; master: requester/memory environment view.
interface yarvi_mem_arb_if;
    logic        core_req;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [3:0]  core_wmask;
    logic        core_gnt;
    logic        core_rvalid;

    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [3:0]  dma_wmask;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic        dma_lock;

    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata, core_wmask,
        output core_gnt, core_rvalid,
        input  dma_req, dma_we, dma_addr, dma_wdata, dma_wmask, dma_lock,
        output dma_gnt, dma_rvalid,
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_rdata,
        output rdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata, core_wmask,
        input  core_gnt, core_rvalid,
        output dma_req, dma_we, dma_addr, dma_wdata, dma_wmask, dma_lock,
        input  dma_gnt, dma_rvalid,
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_rdata,
        input  rdata
    );
endinterface

// File: rtl/yarvi_mem_arb.sv
// Two-requester (core, DMA) single-port memory arbiter with DMA lock and read-return tagging.
// Define MEMARB_FAIRNESS_EN to bound core wins while DMA waits (STARVE_LIMIT).
module yarvi_mem_arb #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic            clock,
    input logic            reset,
    yarvi_mem_arb_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e state_q;
    logic   core_gnt;
    logic   dma_gnt;
    logic   fair_force;
    logic   rd_valid_q;
    logic   rd_owner_q;  // 1: read belongs to DMA

`ifdef MEMARB_FAIRNESS_EN
    localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [CntW-1:0] starve_q;

    assign fair_force = bus.dma_req && (starve_q == CntW'(STARVE_LIMIT));

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_q <= '0;
        end else if (dma_gnt || !bus.dma_req) begin
            starve_q <= '0;
        end else if (core_gnt && (starve_q != CntW'(STARVE_LIMIT))) begin
            starve_q <= starve_q + CntW'(1);
        end
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT != 0);
    assign fair_force          = 1'b0;
`endif

    // The cycle dma_lock drops already arbitrates as idle.
    always_comb begin
        core_gnt = 1'b0;
        dma_gnt  = 1'b0;
        if (!reset) begin
            if (state_q == StLocked && bus.dma_lock) begin
                dma_gnt = bus.dma_req;
            end else begin
                core_gnt = bus.core_req && !fair_force;
                dma_gnt  = bus.dma_req && !core_gnt;
            end
        end
    end

    always_comb begin
        bus.mem_valid = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wmask = '0;
        if (core_gnt) begin
            bus.mem_valid = 1'b1;
            bus.mem_we    = bus.core_we;
            bus.mem_addr  = bus.core_addr;
            bus.mem_wdata = bus.core_wdata;
            bus.mem_wmask = bus.core_wmask;
        end else if (dma_gnt) begin
            bus.mem_valid = 1'b1;
            bus.mem_we    = bus.dma_we;
            bus.mem_addr  = bus.dma_addr;
            bus.mem_wdata = bus.dma_wdata;
            bus.mem_wmask = bus.dma_wmask;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            rd_valid_q <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            state_q    <= ((dma_gnt || state_q == StLocked) && bus.dma_lock) ? StLocked : StIdle;
            rd_valid_q <= (core_gnt && !bus.core_we) || (dma_gnt && !bus.dma_we);
            rd_owner_q <= dma_gnt;
        end
    end

    assign bus.core_gnt    = core_gnt;
    assign bus.dma_gnt     = dma_gnt;
    assign bus.core_rvalid = !reset && rd_valid_q && !rd_owner_q;
    assign bus.dma_rvalid  = !reset && rd_valid_q && rd_owner_q;
    assign bus.rdata       = reset ? '0 : bus.mem_rdata;

endmodule

// File: tb/tb_yarvi_mem_arb.sv
// Directed bench for yarvi_mem_arb: grant/mux checks per cycle, read returns via scoreboard.
module tb_yarvi_mem_arb;

    localparam logic [31:0] RdKey = 32'h5A5A_1234;

    typedef struct packed {
        logic        valid;
        logic        owner;
        logic [31:0] data;
    } rd_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    rd_t  exp_q[$];

    yarvi_mem_arb_if bus ();

    yarvi_mem_arb #(
        .STARVE_LIMIT (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Memory model: read data is a function of the address presented last cycle.
    always @(posedge clock) bus.mem_rdata <= bus.mem_addr ^ RdKey;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_core(input logic req, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wmask);
        bus.core_req   = req;
        bus.core_we    = we;
        bus.core_addr  = addr;
        bus.core_wdata = wdata;
        bus.core_wmask = wmask;
    endtask

    task automatic drive_dma(input logic req, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wmask,
                             input logic lock);
        bus.dma_req   = req;
        bus.dma_we    = we;
        bus.dma_addr  = addr;
        bus.dma_wdata = wdata;
        bus.dma_wmask = wmask;
        bus.dma_lock  = lock;
    endtask

    // Check one cycle against the expected grants, then queue the expected read return.
    task automatic cycle(input logic ecg, input logic edg, input string tag);
        rd_t e;
        rd_t n;
        @(negedge clock);
        if (reset) begin
            exp_q.delete();
            exp_q.push_back('0);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        chk({tag, ".core_gnt"}, {31'b0, bus.core_gnt}, {31'b0, ecg});
        chk({tag, ".dma_gnt"}, {31'b0, bus.dma_gnt}, {31'b0, edg});
        chk({tag, ".core_rvalid"}, {31'b0, bus.core_rvalid}, {31'b0, e.valid && !e.owner});
        chk({tag, ".dma_rvalid"}, {31'b0, bus.dma_rvalid}, {31'b0, e.valid && e.owner});
        if (e.valid) chk({tag, ".rdata"}, bus.rdata, e.data);
        if (reset) chk({tag, ".rdata_rst"}, bus.rdata, 32'h0);
        chk({tag, ".mem_valid"}, {31'b0, bus.mem_valid}, {31'b0, ecg || edg});
        if (ecg) begin
            chk({tag, ".mem_we"}, {31'b0, bus.mem_we}, {31'b0, bus.core_we});
            chk({tag, ".mem_addr"}, bus.mem_addr, bus.core_addr);
            chk({tag, ".mem_wdata"}, bus.mem_wdata, bus.core_wdata);
            chk({tag, ".mem_wmask"}, {28'b0, bus.mem_wmask}, {28'b0, bus.core_wmask});
        end else if (edg) begin
            chk({tag, ".mem_we"}, {31'b0, bus.mem_we}, {31'b0, bus.dma_we});
            chk({tag, ".mem_addr"}, bus.mem_addr, bus.dma_addr);
            chk({tag, ".mem_wdata"}, bus.mem_wdata, bus.dma_wdata);
            chk({tag, ".mem_wmask"}, {28'b0, bus.mem_wmask}, {28'b0, bus.dma_wmask});
        end else begin
            chk({tag, ".mem_wmask"}, {28'b0, bus.mem_wmask}, 32'h0);
        end
        n.valid = (ecg && !bus.core_we) || (edg && !bus.dma_we);
        n.owner = edg;
        n.data  = (edg ? bus.dma_addr : bus.core_addr) ^ RdKey;
        exp_q.push_back(n);
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic fair_d;
        exp_q.push_back('0);
        drive_core(1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'h0);
        drive_dma(1'b1, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 1'b0);

        // Reset holds everything quiet even with both requesting.
        reset = 1'b1;
        cycle(1'b0, 1'b0, "rst0");
        cycle(1'b0, 1'b0, "rst1");
        reset = 1'b0;

        // Simultaneous reads: core first, DMA next, returns in order.
        cycle(1'b1, 1'b0, "sim_c0");
        drive_core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cycle(1'b0, 1'b1, "sim_d1");
        drive_dma(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        cycle(1'b0, 1'b0, "sim_idle");

        // Partial store, then a zero-mask DMA write; neither returns data.
        drive_core(1'b1, 1'b1, 32'h8000_0040, 32'hDEAD_BEEF, 4'hC);
        cycle(1'b1, 1'b0, "st_core");
        drive_core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_dma(1'b1, 1'b1, 32'h8000_0044, 32'h1234_5678, 4'h0, 1'b0);
        cycle(1'b0, 1'b1, "st_dma_m0");
        drive_dma(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        cycle(1'b0, 1'b0, "st_idle");

        // Lock: DMA read with lock, core shut out while lock held.
        drive_dma(1'b1, 1'b0, 32'h8000_0080, 32'h0, 4'h0, 1'b1);
        cycle(1'b0, 1'b1, "lk_d");
        drive_core(1'b1, 1'b0, 32'h8000_0090, 32'h0, 4'h0);
        drive_dma(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        cycle(1'b0, 1'b0, "lk_c1");
        drive_dma(1'b1, 1'b0, 32'h8000_0084, 32'h0, 4'h0, 1'b1);
        cycle(1'b0, 1'b1, "lk_c2");
        drive_dma(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        cycle(1'b0, 1'b0, "lk_c3");
        drive_dma(1'b1, 1'b0, 32'h8000_0088, 32'h0, 4'h0, 1'b0);
        cycle(1'b1, 1'b0, "lk_drop");
        drive_core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_dma(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        cycle(1'b0, 1'b0, "lk_idle");

        // Alternating owners every cycle, no bubbles.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                drive_core(1'b1, 1'b0, 32'h8000_0300 + 32'(i * 4), 32'h0, 4'h0);
                drive_dma(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
                cycle(1'b1, 1'b0, "alt_c");
            end else begin
                drive_core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
                drive_dma(1'b1, 1'b0, 32'h8000_0400 + 32'(i * 4), 32'h0, 4'h0, 1'b0);
                cycle(1'b0, 1'b1, "alt_d");
            end
        end
        drive_core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_dma(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        cycle(1'b0, 1'b0, "alt_idle");

        // Both held: strict core priority, or C,C,C,C,D with fairness.
        for (int i = 0; i < 10; i++) begin
`ifdef MEMARB_FAIRNESS_EN
            fair_d = (i % 5 == 4);
`else
            fair_d = 1'b0;
`endif
            drive_core(1'b1, 1'b0, 32'h8000_0100 + 32'(i * 4), 32'h0, 4'h0);
            drive_dma(1'b1, 1'b0, 32'h8000_0200 + 32'(i * 4), 32'h0, 4'h0, 1'b0);
            cycle(!fair_d, fair_d, "fair");
        end
        drive_core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_dma(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        cycle(1'b0, 1'b0, "fair_idle");

        // Reset right after a locked DMA read: return dropped, core wins after.
        drive_dma(1'b1, 1'b0, 32'h8000_0500, 32'h0, 4'h0, 1'b1);
        cycle(1'b0, 1'b1, "rl_d");
        reset = 1'b1;
        drive_core(1'b1, 1'b0, 32'h8000_0600, 32'h0, 4'h0);
        cycle(1'b0, 1'b0, "rl_rst");
        reset = 1'b0;
        cycle(1'b1, 1'b0, "rl_core");
        drive_core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_dma(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        cycle(1'b0, 1'b0, "rl_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
